// File: rtl/rgb_to_color_code_pkg.sv
// Shared palette definitions for the RGB <-> colour-code display path:
// code values, channel levels and the quantized-bits-to-code mapping.
package rgb_to_color_code_pkg;

    typedef enum logic [2:0] {
        COL_PURPLE    = 3'd0,
        COL_WHITE     = 3'd1,
        COL_BLUE      = 3'd2,
        COL_BLACK     = 3'd3,
        COL_TURQUOISE = 3'd4,
        COL_YELLOW    = 3'd5,
        COL_GREEN     = 3'd6,
        COL_RED       = 3'd7
    } color_e;

    localparam logic [3:0] LVL_ON    = 4'hD;
    localparam logic [3:0] LVL_OFF   = 4'h0;
    localparam logic [3:0] LVL_WHITE = 4'hF;

    typedef struct packed {
        logic rh;
        logic gh;
        logic bh;
    } qbits_t;

    function automatic color_e code_of(input qbits_t q);
        color_e c;
        case ({q.rh, q.gh, q.bh})
            3'b100:  c = COL_RED;
            3'b010:  c = COL_GREEN;
            3'b110:  c = COL_YELLOW;
            3'b011:  c = COL_TURQUOISE;
            3'b000:  c = COL_BLACK;
            3'b001:  c = COL_BLUE;
            3'b111:  c = COL_WHITE;
            default: c = COL_PURPLE;
        endcase
        return c;
    endfunction

    // Palette level a channel must carry for its quantized bit; white is the only full-scale entry.
    function automatic logic [3:0] level_of(input logic hi, input logic white);
        if (white)
            return LVL_WHITE;
        return hi ? LVL_ON : LVL_OFF;
    endfunction

endpackage

// File: rtl/rgb_to_color_code_if.sv
// Pixel-in / code-out stream bundle with miss-counter side signals.
// Valid/ready: a beat transfers on the rising edge where valid && ready; valid holds and data stays stable until it does.
interface rgb_to_color_code_if #(
    parameter int CNT_W = 16
) ();
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_red;
    logic [3:0]       in_green;
    logic [3:0]       in_blue;
    logic             out_valid;
    logic             out_ready;
    logic [2:0]       out_color;
    logic             out_exact;
    logic             clr_count;
    logic [CNT_W-1:0] miss_count;

    modport slave (
        input  in_valid, in_red, in_green, in_blue, out_ready, clr_count,
        output in_ready, out_valid, out_color, out_exact, miss_count
    );

    modport master (
        output in_valid, in_red, in_green, in_blue, out_ready, clr_count,
        input  in_ready, out_valid, out_color, out_exact, miss_count
    );
endinterface

// File: rtl/rgb_quantize.sv
// Combinational channel quantizer: per-channel high bits against THRESH and
// a flag telling whether the pixel is exactly one of the palette colours.
module rgb_quantize
    import rgb_to_color_code_pkg::*;
#(
    parameter logic [3:0] THRESH = 4'h8
) (
    input  logic [3:0] red,
    input  logic [3:0] green,
    input  logic [3:0] blue,
    output qbits_t     q,
    output logic       exact
);
    logic white;

    always_comb begin
        q.rh  = (red   >= THRESH);
        q.gh  = (green >= THRESH);
        q.bh  = (blue  >= THRESH);
        white = q.rh && q.gh && q.bh;
        // A pixel is exact only when every channel sits on the level its own quantized bit implies.
        exact = (red   == level_of(q.rh, white)) &&
                (green == level_of(q.gh, white)) &&
                (blue  == level_of(q.bh, white));
    end
endmodule

// File: rtl/rgb_to_color_code.sv
// Two-stage elastic pipeline: stage 1 holds quantized bits + exact flag,
// stage 2 holds the palette code; also counts non-exact output pixels.
module rgb_to_color_code
    import rgb_to_color_code_pkg::*;
#(
    parameter logic [3:0] THRESH = 4'h8,
    parameter int         CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    rgb_to_color_code_if.slave   bus
);
    qbits_t           q_w;
    logic             exact_w;

    logic             s1_valid_q, s1_valid_d;
    qbits_t           s1_bits_q,  s1_bits_d;
    logic             s1_exact_q, s1_exact_d;
    logic             s2_valid_q, s2_valid_d;
    color_e           s2_color_q, s2_color_d;
    logic             s2_exact_q, s2_exact_d;
    logic [CNT_W-1:0] miss_q,     miss_d;

    logic             s1_move;
    logic             in_ready_w;
    logic             in_fire;
    logic             out_fire;

    rgb_quantize #(.THRESH(THRESH)) u_quantize (
        .red   (bus.in_red),
        .green (bus.in_green),
        .blue  (bus.in_blue),
        .q     (q_w),
        .exact (exact_w)
    );

    always_comb begin
        s1_move    = s1_valid_q && (!s2_valid_q || bus.out_ready);
        in_ready_w = !s1_valid_q || s1_move;
        in_fire    = bus.in_valid && in_ready_w;
        out_fire   = s2_valid_q && bus.out_ready;

        s1_valid_d = in_fire || (s1_valid_q && !s1_move);
        s1_bits_d  = s1_bits_q;
        s1_exact_d = s1_exact_q;
        if (in_fire) begin
            s1_bits_d  = q_w;
            s1_exact_d = exact_w;
        end

        // Stage 2 refills from stage 1 in the same cycle it drains, keeping one pixel per cycle.
        s2_valid_d = s1_move || (s2_valid_q && !bus.out_ready);
        s2_color_d = s2_color_q;
        s2_exact_d = s2_exact_q;
        if (s1_move) begin
            s2_color_d = code_of(s1_bits_q);
            s2_exact_d = s1_exact_q;
        end

        miss_d = miss_q;
        if (bus.clr_count)
            miss_d = '0;
        else if (out_fire && !s2_exact_q && (miss_q != {CNT_W{1'b1}}))
            miss_d = miss_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_bits_q  <= '0;
            s1_exact_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_color_q <= COL_BLACK;
            s2_exact_q <= 1'b0;
            miss_q     <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_bits_q  <= s1_bits_d;
            s1_exact_q <= s1_exact_d;
            s2_valid_q <= s2_valid_d;
            s2_color_q <= s2_color_d;
            s2_exact_q <= s2_exact_d;
            miss_q     <= miss_d;
        end
    end

    assign bus.in_ready   = in_ready_w;
    assign bus.out_valid  = s2_valid_q;
    assign bus.out_color  = s2_color_q;
    assign bus.out_exact  = s2_exact_q;
    assign bus.miss_count = miss_q;
endmodule

// File: tb/tb_rgb_to_color_code.sv
// Bench for rgb_to_color_code: directed palette/threshold/stall/reset cases,
// a narrow-counter instance for saturation, and a long random valid/ready run.
module tb_rgb_to_color_code;
    localparam int NRAND = 10000;

    logic clk;
    logic rst_n;

    rgb_to_color_code_if #(.CNT_W(16)) if0 ();
    rgb_to_color_code_if #(.CNT_W(4))  if4 ();

    rgb_to_color_code #(.THRESH(4'h8), .CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if0)
    );

    rgb_to_color_code #(.THRESH(4'h8), .CNT_W(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if4)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // palette indexed by code: 0 PURPLE .. 7 RED
    logic [3:0] pal_r [0:7] = '{4'hD, 4'hF, 4'h0, 4'h0, 4'h0, 4'hD, 4'h0, 4'hD};
    logic [3:0] pal_g [0:7] = '{4'h0, 4'hF, 4'h0, 4'h0, 4'hD, 4'hD, 4'hD, 4'h0};
    logic [3:0] pal_b [0:7] = '{4'hD, 4'hF, 4'hD, 4'h0, 4'hD, 4'h0, 4'h0, 4'h0};

    // reference model: {code, exact}; code is the palette entry whose thresholded pattern matches
    function automatic logic [3:0] ref_model(input logic [3:0] r, input logic [3:0] g, input logic [3:0] b);
        logic [2:0] code;
        logic       ex;
        code = 3'd0;
        ex   = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (r == pal_r[k] && g == pal_g[k] && b == pal_b[k])
                ex = 1'b1;
            if (((r >= 4'd8) == (pal_r[k] >= 4'd8)) &&
                ((g >= 4'd8) == (pal_g[k] >= 4'd8)) &&
                ((b >= 4'd8) == (pal_b[k] >= 4'd8)))
                code = k[2:0];
        end
        return {code, ex};
    endfunction

    // scoreboard
    logic [3:0]  exp_q[$];
    logic [15:0] model_miss = '0;
    logic        hold_v = 1'b0;
    logic [2:0]  hold_c = 3'd0;
    logic        hold_e = 1'b0;
    logic        probe_en = 1'b0;
    logic        rand_rdy = 1'b0;

    always @(negedge rst_n) begin
        exp_q.delete();
        model_miss = '0;
    end

    always @(negedge clk) begin
        logic [3:0] e;
        logic       fire_ex;
        if (!rst_n) begin
            hold_v = 1'b0;
        end else begin
            total++;
            if (if0.miss_count !== model_miss) begin
                bad++;
                $display("FAIL miss_count t=%0t got=%0d want=%0d", $time, if0.miss_count, model_miss);
            end
            if (hold_v) begin
                total++;
                if (!(if0.out_valid === 1'b1 && if0.out_color === hold_c && if0.out_exact === hold_e)) begin
                    bad++;
                    $display("FAIL stall_hold t=%0t got v=%b c=%0d e=%b want v=1 c=%0d e=%b",
                             $time, if0.out_valid, if0.out_color, if0.out_exact, hold_c, hold_e);
                end
            end
            fire_ex = 1'b1;
            if (if0.out_valid === 1'b1 && if0.out_ready === 1'b1) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    fire_ex = if0.out_exact;
                    $display("FAIL unexpected_output t=%0t got c=%0d e=%b want none",
                             $time, if0.out_color, if0.out_exact);
                end else begin
                    e = exp_q.pop_front();
                    fire_ex = e[0];
                    if ({if0.out_color, if0.out_exact} !== e) begin
                        bad++;
                        $display("FAIL output t=%0t got c=%0d e=%b want c=%0d e=%b",
                                 $time, if0.out_color, if0.out_exact, e[3:1], e[0]);
                    end
                end
            end
            if (if0.clr_count === 1'b1)
                model_miss = '0;
            else if (if0.out_valid === 1'b1 && if0.out_ready === 1'b1 && !fire_ex && model_miss != 16'hFFFF)
                model_miss = model_miss + 16'd1;
            hold_v = (if0.out_valid === 1'b1) && (if0.out_ready === 1'b0);
            hold_c = if0.out_color;
            hold_e = if0.out_exact;
        end
    end

    // in_ready must be the same whatever in_valid is
    always @(negedge clk) begin
        logic a, b;
        if (probe_en && rst_n) begin
            #2;
            a = if0.in_ready;
            if0.in_valid = ~if0.in_valid;
            #1;
            b = if0.in_ready;
            if0.in_valid = ~if0.in_valid;
            total++;
            if (a !== b) begin
                bad++;
                $display("FAIL in_ready_indep t=%0t got=%b want=%b", $time, b, a);
            end
        end
    end

    always @(posedge clk) begin
        if (rand_rdy) begin
            #1;
            if0.out_ready = ($urandom_range(0, 3) != 0);
            if0.clr_count = ($urandom_range(0, 63) == 0);
        end
    end

    // driver tasks
    task automatic send(input logic [3:0] r, input logic [3:0] g, input logic [3:0] b);
        int n;
        n = 0;
        if0.in_valid = 1'b1;
        if0.in_red   = r;
        if0.in_green = g;
        if0.in_blue  = b;
        while (1) begin
            @(negedge clk);
            if (if0.in_ready === 1'b1) begin
                exp_q.push_back(ref_model(r, g, b));
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1;
            n++;
            if (n > 500) begin
                total++; bad++;
                $display("FAIL send_timeout got in_ready=0 want 1");
                break;
            end
        end
        if0.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        if0.out_ready = 1'b1;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain got pending=%0d want 0", exp_q.size());
        end
    endtask

    task automatic check1(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic send4(input logic [3:0] r, input logic [3:0] g, input logic [3:0] b);
        int n;
        n = 0;
        if4.in_valid = 1'b1;
        if4.in_red   = r;
        if4.in_green = g;
        if4.in_blue  = b;
        while (n < 500) begin
            @(negedge clk);
            if (if4.in_ready === 1'b1) break;
            @(posedge clk); #1;
            n++;
        end
        if (n >= 500) begin
            total++; bad++;
            $display("FAIL send4_timeout got in_ready=0 want 1");
        end
        @(posedge clk); #1;
        if4.in_valid = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] pr [0:5];
        logic [3:0] pg [0:5];
        logic [3:0] pb [0:5];
        int         idx;
        int         sent;
        time        t0;
        logic [3:0] r, g, b;
        int         k;

        rst_n = 1'b0;
        if0.in_valid = 1'b0; if0.in_red = '0; if0.in_green = '0; if0.in_blue = '0;
        if0.out_ready = 1'b1; if0.clr_count = 1'b0;
        if4.in_valid = 1'b0; if4.in_red = '0; if4.in_green = '0; if4.in_blue = '0;
        if4.out_ready = 1'b1; if4.clr_count = 1'b0;
        #12;
        check1("rst_out_valid", 32'(if0.out_valid), 0);
        check1("rst_out_color", 32'(if0.out_color), 3);
        check1("rst_out_exact", 32'(if0.out_exact), 0);
        check1("rst_miss", 32'(if0.miss_count), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check1("rst_in_ready", 32'(if0.in_ready), 1);

        // exact palette, back to back, codes 7..0
        t0 = $time;
        send(pal_r[7], pal_g[7], pal_b[7]);
        check1("latency_edge1_valid", 32'(if0.out_valid), 0);
        send(pal_r[6], pal_g[6], pal_b[6]);
        check1("latency_edge2_valid", 32'(if0.out_valid), 1);
        for (int c = 5; c >= 0; c--)
            send(pal_r[c], pal_g[c], pal_b[c]);
        check1("throughput_time", 32'($time - t0), 80);
        drain();
        check1("palette_miss", 32'(if0.miss_count), 0);

        // non-exact pixels including the threshold boundary
        send(4'h9, 4'h2, 4'hC);
        send(4'hD, 4'hD, 4'hD);
        send(4'h7, 4'h8, 4'h0);
        drain();
        check1("nonexact_miss", 32'(if0.miss_count), 3);

        // reset with pixels in flight
        if0.out_ready = 1'b0;
        send(4'hD, 4'h0, 4'h0);
        send(4'h0, 4'hD, 4'h0);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check1("midrst_out_valid", 32'(if0.out_valid), 0);
        check1("midrst_miss", 32'(if0.miss_count), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        if0.out_ready = 1'b1;
        @(posedge clk); #1;
        check1("midrst_in_ready", 32'(if0.in_ready), 1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check1("midrst_no_stale", 32'(if0.out_valid), 0);
        end

        // stall: out_ready low for 6 cycles with a stream pending
        for (int i = 0; i < 6; i++) begin
            pr[i] = 4'(i + 1);
            pg[i] = 4'(14 - i);
            pb[i] = 4'(i * 3);
        end
        if0.out_ready = 1'b0;
        idx = 0;
        if0.in_valid = 1'b1;
        for (int cyc = 0; cyc < 6; cyc++) begin
            if0.in_red = pr[idx]; if0.in_green = pg[idx]; if0.in_blue = pb[idx];
            @(negedge clk);
            if (if0.in_ready === 1'b1) begin
                exp_q.push_back(ref_model(pr[idx], pg[idx], pb[idx]));
                idx++;
            end
            @(posedge clk); #1;
        end
        if0.in_valid = 1'b0;
        check1("stall_accepted", 32'(idx), 2);
        check1("stall_in_ready", 32'(if0.in_ready), 0);
        if0.out_ready = 1'b1;
        for (int i = idx; i < 6; i++)
            send(pr[i], pg[i], pb[i]);
        drain();

        // narrow counter saturation and clear-wins
        sent = 0;
        for (int i = 0; i < 20; i++) begin
            send4(4'hD, 4'hD, 4'hD);
            sent++;
        end
        repeat (4) @(posedge clk);
        #1;
        check1("sat_miss", 32'(if4.miss_count), (sent > 15) ? 15 : sent);
        if4.in_valid = 1'b1;
        if4.in_red = 4'h1; if4.in_green = 4'h9; if4.in_blue = 4'h3;
        @(posedge clk); #1;
        if4.in_valid = 1'b0;
        k = 0;
        while (k < 20) begin
            @(negedge clk);
            if (if4.out_valid === 1'b1) break;
            k++;
        end
        check1("clr_race_outvalid", 32'(if4.out_valid), 1);
        #1;
        if4.clr_count = 1'b1;
        @(posedge clk); #1;
        if4.clr_count = 1'b0;
        check1("clr_race_miss", 32'(if4.miss_count), 0);
        send4(4'h9, 4'h9, 4'h9);
        repeat (3) @(posedge clk);
        #1;
        check1("after_clr_miss", 32'(if4.miss_count), 1);

        // random valid/ready against the reference model
        probe_en = 1'b1;
        rand_rdy = 1'b1;
        for (int i = 0; i < NRAND; i++) begin
            if ($urandom_range(0, 1) == 0) begin
                k = $urandom_range(0, 7);
                r = pal_r[k]; g = pal_g[k]; b = pal_b[k];
            end else begin
                r = 4'($urandom_range(0, 15));
                g = 4'($urandom_range(0, 15));
                b = 4'($urandom_range(0, 15));
            end
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
            send(r, g, b);
        end
        rand_rdy = 1'b0;
        @(posedge clk); #2;
        if0.clr_count = 1'b0;
        drain();
        probe_en = 1'b0;
        check1("random_final_miss", 32'(if0.miss_count), 32'(model_miss));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
